// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO initiator: request record, FSM states
// and the data pattern returned when a read is never answered.
package pio_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    localparam logic [DATA_W_DEF-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic                  rw;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } pio_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT_RD,
        ST_RSP
    } pio_state_e;

    function automatic pio_req_t packReq(input logic rw,
                                         input logic [ADDR_W_DEF-1:0] addr,
                                         input logic [DATA_W_DEF-1:0] data);
        pio_req_t req;
        req.rw   = rw;
        req.addr = addr;
        req.data = data;
        return req;
    endfunction

endpackage

// File: rtl/pio_if.sv
// Point-to-point PIO link between one initiator and one responder.
interface pio_if #(
    parameter int ADDR_W = pio_pkg::ADDR_W_DEF,
    parameter int DATA_W = pio_pkg::DATA_W_DEF
) ();
    logic              cmd_vld;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_w;
    logic [DATA_W-1:0] data_r;
    logic              rd_vld;

    modport master (output cmd_vld, rw, addr, data_w, input data_r, rd_vld);
    modport slave  (input cmd_vld, rw, addr, data_w, output data_r, rd_vld);
endinterface

// File: rtl/pio_req_fifo.sv
// Request queue in front of the PIO FSM; head entry is visible combinationally
// so the FSM can pop and register it on the same edge.
module pio_req_fifo
    import pio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_push,
    input  pio_req_t i_data,
    input  logic     i_pop,
    output pio_req_t o_data,
    output logic     o_full,
    output logic     o_empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    pio_req_t    r_mem [DEPTH];
    logic        w_doPush;
    logic        w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_data   = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/pio_master.sv
// PIO initiator: queues host requests and issues them one at a time, posting
// writes and waiting (with timeout) for read data before the next command.
module pio_master
    import pio_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              stray_rd,
    pio_if.master             pio
);
    localparam int CNT_W = $clog2(TIMEOUT);

    pio_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cmdVld;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dataW;
    logic              r_rspVld;
    logic [DATA_W-1:0] r_rspData;
    logic              r_rspErr;
    logic              r_strayRd;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    pio_req_t          w_head;

    assign w_push = req_vld && !w_full;
    // Pop from IDLE, or straight out of CMD after a write to stream back-to-back writes.
    assign w_pop  = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_CMD && r_rw));

    pio_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (packReq(req_rw, req_addr, req_data)),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cmdVld  <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_dataW   <= '0;
            r_rspVld  <= 1'b0;
            r_rspData <= '0;
            r_rspErr  <= 1'b0;
            r_strayRd <= 1'b0;
        end else begin
            r_strayRd <= pio.rd_vld && (r_state != ST_WAIT_RD);
            if (w_pop) begin
                r_rw     <= w_head.rw;
                r_addr   <= w_head.addr;
                r_dataW  <= w_head.data;
                r_cmdVld <= 1'b1;
                r_state  <= ST_CMD;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_CMD: begin
                        r_cmdVld <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= r_rw ? ST_IDLE : ST_WAIT_RD;
                    end
                    ST_WAIT_RD: begin
                        // A response landing on the final timeout cycle still counts as good data.
                        if (pio.rd_vld) begin
                            r_rspData <= pio.data_r;
                            r_rspErr  <= 1'b0;
                            r_rspVld  <= 1'b1;
                            r_state   <= ST_RSP;
                        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                            r_rspData <= TIMEOUT_DATA;
                            r_rspErr  <= 1'b1;
                            r_rspVld  <= 1'b1;
                            r_state   <= ST_RSP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_RSP: begin
                        if (rsp_rdy) begin
                            r_rspVld <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign req_rdy     = !w_full;
    assign busy        = !w_empty || (r_state != ST_IDLE);
    assign rsp_vld     = r_rspVld;
    assign rsp_data    = r_rspData;
    assign rsp_err     = r_rspErr;
    assign stray_rd    = r_strayRd;
    assign pio.cmd_vld = r_cmdVld;
    assign pio.rw      = r_rw;
    assign pio.addr    = r_addr;
    assign pio.data_w  = r_dataW;

endmodule

// File: tb/tb_pio_master.sv
// Directed bench for pio_master: a table of single transactions plus hand-written
// sequences for queue-full stalls, held responses, stray read data and mid-read reset.
module tb_pio_master;
    import pio_pkg::*;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_vld;
    logic        req_rdy;
    logic        req_rw;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        stray_rd;

    int checks = 0;
    int errors = 0;

    pio_if #(.ADDR_W(16), .DATA_W(32)) pioBus ();

    pio_master #(
        .ADDR_W     (16),
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_rw   (req_rw),
        .req_addr (req_addr),
        .req_data (req_data),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .stray_rd (stray_rd),
        .pio      (pioBus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          rdDelay;
        logic [31:0] rdData;
        logic [31:0] expData;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic rw, input logic [15:0] addr, input logic [31:0] data);
        req_vld  = vld;
        req_rw   = rw;
        req_addr = addr;
        req_data = data;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " cmd_vld"},  {31'b0, pioBus.cmd_vld}, 32'h0);
        checkOutput({tag, " rw"},       {31'b0, pioBus.rw},      32'h0);
        checkOutput({tag, " addr"},     {16'b0, pioBus.addr},    32'h0);
        checkOutput({tag, " data_w"},   pioBus.data_w,           32'h0);
        checkOutput({tag, " req_rdy"},  {31'b0, req_rdy},        32'h1);
        checkOutput({tag, " rsp_vld"},  {31'b0, rsp_vld},        32'h0);
        checkOutput({tag, " rsp_data"}, rsp_data,                32'h0);
        checkOutput({tag, " rsp_err"},  {31'b0, rsp_err},        32'h0);
        checkOutput({tag, " busy"},     {31'b0, busy},           32'h0);
        checkOutput({tag, " stray_rd"}, {31'b0, stray_rd},       32'h0);
    endtask

    // One request from the table: push, see the command two cycles later, then
    // for reads play the responder and time the response from the command cycle.
    task automatic runVector(input vec_t v);
        int lat;
        @(negedge clk);
        checkOutput("vec req_rdy", {31'b0, req_rdy}, 32'h1);
        applyStimulus(1'b1, v.rw, v.addr, v.wdata);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
        checkOutput("vec cmd_vld early", {31'b0, pioBus.cmd_vld}, 32'h0);
        @(negedge clk);
        checkOutput("vec cmd_vld", {31'b0, pioBus.cmd_vld}, 32'h1);
        checkOutput("vec rw",      {31'b0, pioBus.rw},      {31'b0, v.rw});
        checkOutput("vec addr",    {16'b0, pioBus.addr},    {16'b0, v.addr});
        if (v.rw) begin
            checkOutput("vec data_w", pioBus.data_w, v.wdata);
            @(negedge clk);
            checkOutput("vec write cmd_vld drop", {31'b0, pioBus.cmd_vld}, 32'h0);
            checkOutput("vec write busy", {31'b0, busy}, 32'h0);
        end else begin
            lat = 0;
            for (int k = 1; k <= 200; k++) begin
                @(negedge clk);
                if (rsp_vld) begin
                    lat = k;
                    break;
                end
                pioBus.rd_vld = (k == v.rdDelay);
                pioBus.data_r = (k == v.rdDelay) ? v.rdData : 32'h7777_7777;
            end
            pioBus.rd_vld = 1'b0;
            pioBus.data_r = 32'h7777_7777;
            checkOutput("vec rsp latency", lat, v.expLat);
            checkOutput("vec rsp_data", rsp_data, v.expData);
            checkOutput("vec rsp_err", {31'b0, rsp_err}, {31'b0, v.expErr});
            rsp_rdy = 1'b1;
            @(negedge clk);
            rsp_rdy = 1'b0;
            checkOutput("vec rsp_vld drop", {31'b0, rsp_vld}, 32'h0);
            checkOutput("vec read busy", {31'b0, busy}, 32'h0);
            checkOutput("vec stray_rd", {31'b0, stray_rd}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h0000, 32'h1234_5678, 0,  32'h0,         32'h0,         1'b0, 0};
        vecs[1] = '{1'b0, 16'h1000, 32'h0,         1,  32'h1234_5678, 32'h1234_5678, 1'b0, 2};
        vecs[2] = '{1'b0, 16'h0004, 32'h0,         3,  32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 4};
        vecs[3] = '{1'b0, 16'h2000, 32'h0,         0,  32'h0,         32'hDEAD_BEEF, 1'b1, 65};
        vecs[4] = '{1'b0, 16'h0008, 32'h0,         64, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 65};
        vecs[5] = '{1'b0, 16'h7FFE, 32'h0,         63, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 64};
        vecs[6] = '{1'b1, 16'h8001, 32'hCAFE_F00D, 0,  32'h0,         32'h0,         1'b0, 0};
        vecs[7] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 0,  32'h0,         32'h0,         1'b0, 0};

        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
        rsp_rdy       = 1'b0;
        pioBus.rd_vld = 1'b0;
        pioBus.data_r = 32'h7777_7777;

        repeat (3) @(negedge clk);
        checkResetValues("in reset");
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("after reset");

        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i]);
        end

        // Late read data while idle: one stray pulse, nothing else happens.
        @(negedge clk);
        pioBus.rd_vld = 1'b1;
        pioBus.data_r = 32'h4444_4444;
        @(negedge clk);
        pioBus.rd_vld = 1'b0;
        checkOutput("stray pulse", {31'b0, stray_rd}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stray pulse end", {31'b0, stray_rd}, 32'h0);
            checkOutput("stray no rsp", {31'b0, rsp_vld}, 32'h0);
            checkOutput("stray no cmd", {31'b0, pioBus.cmd_vld}, 32'h0);
        end

        // Read held in RSP while four writes fill the queue, then a fifth request stalls.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h3000, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 16'h8000, 32'h8000_0000);
        @(negedge clk);
        checkOutput("fill read cmd_vld", {31'b0, pioBus.cmd_vld}, 32'h1);
        checkOutput("fill read addr", {16'b0, pioBus.addr}, 32'h3000);
        checkOutput("fill read rw", {31'b0, pioBus.rw}, 32'h0);
        applyStimulus(1'b1, 1'b1, 16'h8001, 32'h8000_0001);
        @(negedge clk);
        pioBus.rd_vld = 1'b1;
        pioBus.data_r = 32'h5555_AAAA;
        applyStimulus(1'b1, 1'b1, 16'h8002, 32'h8000_0002);
        @(negedge clk);
        pioBus.rd_vld = 1'b0;
        pioBus.data_r = 32'h7777_7777;
        checkOutput("fill rsp_vld", {31'b0, rsp_vld}, 32'h1);
        checkOutput("fill req_rdy before full", {31'b0, req_rdy}, 32'h1);
        applyStimulus(1'b1, 1'b1, 16'h8003, 32'h8000_0003);
        @(negedge clk);
        checkOutput("full req_rdy", {31'b0, req_rdy}, 32'h0);
        applyStimulus(1'b1, 1'b0, 16'h0010, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("held rsp_vld", {31'b0, rsp_vld}, 32'h1);
            checkOutput("held rsp_data", rsp_data, 32'h5555_AAAA);
            checkOutput("held rsp_err", {31'b0, rsp_err}, 32'h0);
            checkOutput("held no cmd", {31'b0, pioBus.cmd_vld}, 32'h0);
            checkOutput("held req_rdy", {31'b0, req_rdy}, 32'h0);
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        checkOutput("release rsp_vld", {31'b0, rsp_vld}, 32'h0);
        checkOutput("release no cmd", {31'b0, pioBus.cmd_vld}, 32'h0);
        checkOutput("release req_rdy", {31'b0, req_rdy}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("drain req_rdy", {31'b0, req_rdy}, 32'h1);
            if (i == 1) applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
            checkOutput("b2b cmd_vld", {31'b0, pioBus.cmd_vld}, 32'h1);
            checkOutput("b2b rw", {31'b0, pioBus.rw}, 32'h1);
            checkOutput("b2b addr", {16'b0, pioBus.addr}, 32'h8000 + i);
            checkOutput("b2b data_w", pioBus.data_w, 32'h8000_0000 + i);
        end
        @(negedge clk);
        checkOutput("queued read cmd_vld", {31'b0, pioBus.cmd_vld}, 32'h1);
        checkOutput("queued read rw", {31'b0, pioBus.rw}, 32'h0);
        checkOutput("queued read addr", {16'b0, pioBus.addr}, 32'h0010);
        @(negedge clk);
        checkOutput("queued read cmd drop", {31'b0, pioBus.cmd_vld}, 32'h0);
        pioBus.rd_vld = 1'b1;
        pioBus.data_r = 32'h0102_0304;
        @(negedge clk);
        pioBus.rd_vld = 1'b0;
        pioBus.data_r = 32'h7777_7777;
        checkOutput("queued read rsp_vld", {31'b0, rsp_vld}, 32'h1);
        checkOutput("queued read rsp_data", rsp_data, 32'h0102_0304);
        checkOutput("queued read rsp_err", {31'b0, rsp_err}, 32'h0);
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        checkOutput("queued read done", {31'b0, rsp_vld}, 32'h0);
        checkOutput("queued read idle", {31'b0, busy}, 32'h0);

        // Reset while a read is outstanding and two requests are queued.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h4000, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 16'h8010, 32'h1111_1111);
        @(negedge clk);
        checkOutput("pre-reset cmd_vld", {31'b0, pioBus.cmd_vld}, 32'h1);
        checkOutput("pre-reset addr", {16'b0, pioBus.addr}, 32'h4000);
        applyStimulus(1'b1, 1'b1, 16'h8011, 32'h2222_2222);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
        checkOutput("pre-reset busy", {31'b0, busy}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("mid-read reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("post-reset no cmd", {31'b0, pioBus.cmd_vld}, 32'h0);
            checkOutput("post-reset no rsp", {31'b0, rsp_vld}, 32'h0);
            checkOutput("post-reset busy", {31'b0, busy}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
